// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter for the VGA adapter pixel-write port, with a
// built-in full-frame clear sweep that runs after reset or on request.
module vga_plot_arbiter #(
    parameter int         WIDTH        = 160,
    parameter int         HEIGHT       = 120,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_req,
    input  logic [2:0]  req,
    input  logic [23:0] req_x,
    input  logic [20:0] req_y,
    input  logic [8:0]  req_colour,
    output logic [2:0]  ack,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        clear_busy
);

    localparam logic [7:0] W_LAST = 8'(WIDTH - 1);
    localparam logic [6:0] H_LAST = 7'(HEIGHT - 1);

    typedef enum logic {S_CLEAR, S_SERVE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cx_q, cx_d;
    logic [6:0]  cy_q, cy_d;
    logic [7:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic [2:0]  colour_q, colour_d;
    logic        plot_q, plot_d;
    logic [2:0]  ack_q, ack_d;
    logic [1:0]  p_q, p_d;

    logic [2:0]  elig;
    logic [2:0]  cand;
    logic        found;
    logic [1:0]  gsel;
    logic [7:0]  gx;
    logic [6:0]  gy;
    logic [2:0]  gc;

    always_comb begin
        state_d  = state_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        p_d      = p_q;
        plot_d   = 1'b0;
        ack_d    = 3'b000;
        found    = 1'b0;
        gsel     = 2'd0;
        cand     = 3'd0;
        gx       = 8'd0;
        gy       = 7'd0;
        gc       = 3'd0;

        // The requester acked this cycle is masked to avoid replotting stale data.
        elig = req & ~ack_q;

        for (int k = 0; k < 3; k++) begin
            cand = {1'b0, p_q} + 3'(k);
            if (cand >= 3'd3) cand = cand - 3'd3;
            if (!found && elig[cand[1:0]]) begin
                found = 1'b1;
                gsel  = cand[1:0];
            end
        end

        case (gsel)
            2'd1: begin
                gx = req_x[15:8];
                gy = req_y[13:7];
                gc = req_colour[5:3];
            end
            2'd2: begin
                gx = req_x[23:16];
                gy = req_y[20:14];
                gc = req_colour[8:6];
            end
            default: begin
                gx = req_x[7:0];
                gy = req_y[6:0];
                gc = req_colour[2:0];
            end
        endcase

        case (state_q)
            S_CLEAR: begin
                x_d      = cx_q;
                y_d      = cy_q;
                colour_d = CLEAR_COLOUR;
                plot_d   = 1'b1;
                if (cx_q == W_LAST) begin
                    cx_d = 8'd0;
                    if (cy_q == H_LAST) begin
                        cy_d    = 7'd0;
                        state_d = S_SERVE;
                    end else begin
                        cy_d = cy_q + 7'd1;
                    end
                end else begin
                    cx_d = cx_q + 8'd1;
                end
            end
            default: begin
                if (clear_req) begin
                    state_d = S_CLEAR;
                    cx_d    = 8'd0;
                    cy_d    = 7'd0;
                end else if (found) begin
                    ack_d    = 3'b001 << gsel;
                    x_d      = gx;
                    y_d      = gy;
                    colour_d = gc;
                    // Off-screen pixels are acked but never written.
                    plot_d   = (gx <= W_LAST) && (gy <= H_LAST);
                    p_d      = (gsel == 2'd2) ? 2'd0 : gsel + 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_CLEAR;
            cx_q     <= 8'd0;
            cy_q     <= 7'd0;
            x_q      <= 8'd0;
            y_q      <= 7'd0;
            colour_q <= 3'd0;
            plot_q   <= 1'b0;
            ack_q    <= 3'b000;
            p_q      <= 2'd0;
        end else begin
            state_q  <= state_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            ack_q    <= ack_d;
            p_q      <= p_d;
        end
    end

    assign ack        = ack_q;
    assign x          = x_q;
    assign y          = y_q;
    assign colour     = colour_q;
    assign plot       = plot_q;
    assign clear_busy = (state_q == S_CLEAR);

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter: clear sweep, round-robin
// grants, clear priority, off-screen drop and mid-sweep reset.
module tb_vga_plot_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear_req;
    logic [2:0]  req;
    logic [23:0] req_x;
    logic [20:0] req_y;
    logic [8:0]  req_colour;
    logic [2:0]  ack;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        clear_busy;

    int n_tests = 0;
    int n_fail  = 0;

    vga_plot_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .clear_req  (clear_req),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_colour (req_colour),
        .ack        (ack),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .clear_busy (clear_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rq(input int i, input int px, input int py,
                          input int pc);
        req_x[8*i +: 8]      = 8'(px);
        req_y[7*i +: 7]      = 7'(py);
        req_colour[3*i +: 3] = 3'(pc);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_x"}, {24'd0, x}, 32'd0);
        chk({tag, "_y"}, {25'd0, y}, 32'd0);
        chk({tag, "_col"}, {29'd0, colour}, 32'd0);
        chk({tag, "_plot"}, {31'd0, plot}, 32'd0);
        chk({tag, "_ack"}, {29'd0, ack}, 32'd0);
        chk({tag, "_busy"}, {31'd0, clear_busy}, 32'd1);
    endtask

    // Walks the full sweep; per-pixel errors are tallied then compared once.
    task automatic run_sweep(input string tag);
        int bad_pix;
        int bad_ack;
        int bad_busy;
        bad_pix  = 0;
        bad_ack  = 0;
        bad_busy = 0;
        for (int n = 0; n < 19200; n++) begin
            tick();
            if (plot !== 1'b1 || colour !== 3'b000 ||
                int'(x) != n % 160 || int'(y) != n / 160)
                bad_pix++;
            if (ack !== 3'b000) bad_ack++;
            if (clear_busy !== (n != 19199)) bad_busy++;
            if (n == 0)
                chk({tag, "_p1"}, {17'd0, x, y}, {17'd0, 8'd0, 7'd0});
            if (n == 159)
                chk({tag, "_p160"}, {17'd0, x, y}, {17'd0, 8'd159, 7'd0});
            if (n == 160)
                chk({tag, "_p161"}, {17'd0, x, y}, {17'd0, 8'd0, 7'd1});
            if (n == 19199) begin
                chk({tag, "_p19200"}, {17'd0, x, y},
                    {17'd0, 8'd159, 7'd119});
                chk({tag, "_busy_fall"}, {31'd0, clear_busy}, 32'd0);
            end
        end
        chk({tag, "_pixels"}, bad_pix, 0);
        chk({tag, "_noack"}, bad_ack, 0);
        chk({tag, "_busy"}, bad_busy, 0);
    endtask

    initial begin
        reset      = 1'b1;
        clear_req  = 1'b0;
        req        = 3'b000;
        req_x      = '0;
        req_y      = '0;
        req_colour = '0;

        tick();
        chk_reset_vals("rst");
        reset = 1'b0;
        run_sweep("sweep1");
        tick();
        chk("post_sweep_plot", {31'd0, plot}, 32'd0);
        chk("post_sweep_ack", {29'd0, ack}, 32'd0);

        // Single requester held high: ack every other cycle.
        set_rq(1, 10, 1, 4);
        req = 3'b010;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k % 2 == 0) begin
                chk($sformatf("solo_ack%0d", k), {29'd0, ack}, 32'b010);
                chk($sformatf("solo_px%0d", k), {14'd0, plot, x, y, colour},
                    {14'd0, 1'b1, 8'd10, 7'd1, 3'd4});
            end else begin
                chk($sformatf("solo_ack%0d", k), {29'd0, ack}, 32'b000);
                chk($sformatf("solo_plot%0d", k), {31'd0, plot}, 32'd0);
            end
        end

        // One grant to requester 2 moves the pointer back to 0.
        set_rq(2, 5, 6, 3);
        req = 3'b100;
        tick();
        chk("p_realign_ack", {29'd0, ack}, 32'b100);
        req = 3'b000;
        tick();
        chk("idle_ack", {29'd0, ack}, 32'b000);

        // Three continuous requesters rotate 0,1,2.
        set_rq(0, 1, 2, 1);
        set_rq(1, 3, 4, 2);
        req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("rr_ack%0d", k), {29'd0, ack},
                {29'd0, 3'b001 << (k % 3)});
            chk($sformatf("rr_px%0d", k), {14'd0, plot, x, y, colour},
                {14'd0, 1'b1, 8'(2 * (k % 3) + 1), 7'(2 * (k % 3) + 2),
                 3'((k % 3) + 1)});
        end

        // Clear request wins over the newly raised req[2].
        req       = 3'b100;
        clear_req = 1'b1;
        tick();
        chk("clr_edge_plot", {31'd0, plot}, 32'd0);
        chk("clr_edge_ack", {29'd0, ack}, 32'd0);
        chk("clr_edge_busy", {31'd0, clear_busy}, 32'd1);
        clear_req = 1'b0;
        run_sweep("sweep2");
        tick();
        chk("after_clr_ack", {29'd0, ack}, 32'b100);
        chk("after_clr_px", {14'd0, plot, x, y, colour},
            {14'd0, 1'b1, 8'd5, 7'd6, 3'd3});
        req = 3'b000;

        // Off-screen pixel is acked but not plotted.
        set_rq(0, 160, 5, 7);
        req = 3'b001;
        tick();
        chk("oob_ack", {29'd0, ack}, 32'b001);
        chk("oob_plot", {31'd0, plot}, 32'd0);
        set_rq(0, 159, 119, 6);
        tick();
        chk("edge_masked_ack", {29'd0, ack}, 32'b000);
        tick();
        chk("edge_ack", {29'd0, ack}, 32'b001);
        chk("edge_px", {14'd0, plot, x, y, colour},
            {14'd0, 1'b1, 8'd159, 7'd119, 3'd6});
        req = 3'b000;

        // Reset during a sweep at (50,30); pointer is 1 before reset.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int n = 0; n < 30 * 160 + 51; n++) tick();
        chk("mid_xy", {17'd0, x, y}, {17'd0, 8'd50, 7'd30});
        reset = 1'b1;
        tick();
        chk_reset_vals("rst2");
        reset = 1'b0;
        run_sweep("sweep3");
        req = 3'b011;
        tick();
        chk("p_reset_ack", {29'd0, ack}, 32'b001);
        req = 3'b000;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_plot_arbiter.md
# vga_plot_arbiter

Shares the single VGA adapter pixel-write port (x, y, colour, plot) among three pixel requesters: user ship, enemy ship and bullet renderers. A built-in clear engine sweeps the full 160x120 frame to a fixed colour after reset or on demand. Arbitration between requesters is round-robin at one pixel per clock. The block sits between the game-object renderers and the VGA adapter.

## Interface
- WIDTH, 160, frame width in pixels
- HEIGHT, 120, frame height in pixels
- CLEAR_COLOUR, 3'b000, colour written by the clear sweep
- clk  in  1  system clock (50 MHz)
- reset  in  1  reset, synchronous, active-high
- clear_req  in  1  request a full-frame clear; level or pulse, sampled each edge
- req  in  3  per-requester pixel request; bit i = requester i
- req_x  in  24  requester i x at bits [8i+7:8i]
- req_y  in  21  requester i y at bits [7i+6:7i]
- req_colour  in  9  requester i colour at bits [3i+2:3i]
- ack  out  3  one-cycle acknowledge; bit i = requester i's pixel accepted
- x  out  8  pixel x to VGA adapter
- y  out  7  pixel y to VGA adapter
- colour  out  3  pixel colour to VGA adapter
- plot  out  1  write enable to VGA adapter
- clear_busy  out  1  high while the block is in state CLEAR

## Operation
- States: CLEAR and SERVE. Reset forces CLEAR with sweep counters cx=0, cy=0.
- CLEAR:
  - Each edge registers x=cx, y=cy, colour=CLEAR_COLOUR, plot=1.
  - cx increments each edge. At cx=WIDTH-1 it wraps to 0 and cy increments.
  - The edge that registers (WIDTH-1, HEIGHT-1) also sets state to SERVE.
  - No grants are issued in CLEAR; ack stays 0.
  - clear_req is ignored in CLEAR. The sweep is not restarted.
- SERVE:
  - Requester i is eligible iff req[i]=1 and ack[i]=0. Masking the requester acked in the current cycle prevents a double-plot of stale data.
  - Round-robin: priority starts at pointer p (0..2), then p+1, p+2 mod 3. After granting i, p becomes (i+1) mod 3.
  - Grant i at an edge registers: ack=one-hot(i), x/y/colour = requester i's fields, plot=1.
  - If the granted coordinates are out of range (x>=WIDTH or y>=HEIGHT), the pixel is still acked but plot=0. The pixel is dropped.
  - With no eligible requester: plot=0, ack=0; x, y and colour hold their last values.
  - clear_req=1 at an edge in SERVE takes priority over any grant at that edge. That edge sets state to CLEAR with cx=cy=0 and registers plot=0, ack=0. The sweep starts on the following edge.
- Requester rules:
  - Hold req and data stable until ack is seen.
  - Data may change on the edge after ack.
  - req held high after ack means a new pixel request.

## Timing
- Reset values: x=0, y=0, colour=0, plot=0, ack=0, p=0, clear_busy=1, state CLEAR.
- First non-reset edge after reset plots (0,0).
- Full sweep takes exactly WIDTH*HEIGHT = 19200 consecutive plot cycles.
- clear_busy is a function of state only. It goes low in the cycle presenting pixel (159,119).
- Earliest grant is at the edge after the one that registered (159,119).
- Request-to-ack latency: 1 edge minimum when uncontested; at most 3 edges with three continuous requesters.
- Per-requester throughput is at most 1 pixel per 2 cycles. Aggregate throughput is 1 pixel per cycle.
- ack, x, y, colour and plot change on the same edge, so ack[i]=1 marks exactly the cycle in which requester i's pixel is on the outputs.
- Reset mid-sweep or mid-serve aborts immediately. The next sweep restarts at (0,0), and p returns to 0.

## Test plan
- Reset, then run 19200 cycles:
  - plot=1 on every cycle, colour=000.
  - Pixel 1 is (0,0), pixel 160 is (159,0), pixel 161 is (0,1), pixel 19200 is (159,119).
  - clear_busy falls in the pixel-19200 cycle; plot=0 on the next cycle.
- In SERVE, req=3'b010 held with x=10, y=1, colour=100:
  - ack[1] alternates 1,0,1,0.
  - Every ack cycle shows plot=1 and outputs (10,1,100); no other ack bits rise.
- In SERVE with p=0, req=3'b111 held with distinct coordinates:
  - Grant order is 0,1,2,0,1,2 on consecutive edges.
  - plot=1 every cycle with the matching coordinates.
- In SERVE, clear_req pulsed at the same edge req[2] rises:
  - ack[2]=0 for the 1+19200 cycles of the clear.
  - The first grant after clear_busy falls is to requester 2.
- Requester 0 presents x=160, y=5:
  - ack[0]=1 and plot=0 in that cycle.
  - Requester 0 presents x=159, y=119: ack[0]=1 and plot=1.
- Assert reset for one cycle while the sweep is at (50,30):
  - All outputs take reset values.
  - The next edge plots (0,0).
  - The sweep again takes the full 19200 cycles.
